// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - round-robin arbiter sharing one sprite drawer among three requesters
module draw_arbiter #(
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] req,
    input  logic [8:0] x0,
    input  logic [8:0] x1,
    input  logic [8:0] x2,
    input  logic [7:0] y0,
    input  logic [7:0] y1,
    input  logic [7:0] y2,
    input  logic [1:0] spr0,
    input  logic [1:0] spr1,
    input  logic [1:0] spr2,
    input  logic       drw_done,
    output logic       drw_start,
    output logic [8:0] drw_x,
    output logic [7:0] drw_y,
    output logic [1:0] drw_spr,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  winner_q, winner_d;
    logic [1:0]  last_q, last_d;
    logic [16:0] cnt_q, cnt_d;
    logic        start_q, start_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  spr_q, spr_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic        terr_q, terr_d;
    logic [1:0]  pick;

    // Search order starts one past the previous winner, wrapping modulo 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p0, p1, p2;
        case (last)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        if (r[p0])      rr_pick = p0;
        else if (r[p1]) rr_pick = p1;
        else            rr_pick = p2;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] w);
        onehot = 3'b001 << w;
    endfunction

    assign pick = rr_pick(req, last_q);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        spr_d    = spr_q;
        grant_d  = grant_q;
        start_d  = 1'b0;
        done_d   = 3'b000;
        terr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = START;
                    winner_d = pick;
                    grant_d  = onehot(pick);
                    start_d  = 1'b1;
                    case (pick)
                        2'd0:    begin x_d = x0; y_d = y0; spr_d = spr0; end
                        2'd1:    begin x_d = x1; y_d = y1; spr_d = spr1; end
                        default: begin x_d = x2; y_d = y2; spr_d = spr2; end
                    endcase
                end
            end
            START: begin
                state_d = BUSY;
                cnt_d   = 17'd0;
            end
            BUSY: begin
                // A completion in the limit cycle still counts as a normal finish.
                if (drw_done) begin
                    state_d = DONE;
                    done_d  = onehot(winner_q);
                end else if (cnt_q == LIMIT) begin
                    state_d = DONE;
                    done_d  = onehot(winner_q);
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 3'b000;
                last_d  = winner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            winner_q <= 2'd0;
            last_q   <= 2'd2;
            cnt_q    <= 17'd0;
            start_q  <= 1'b0;
            x_q      <= 9'd0;
            y_q      <= 8'd0;
            spr_q    <= 2'd0;
            grant_q  <= 3'b000;
            done_q   <= 3'b000;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            x_q      <= x_d;
            y_q      <= y_d;
            spr_q    <= spr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
        end
    end

    assign drw_start   = start_q;
    assign drw_x       = x_q;
    assign drw_y       = y_q;
    assign drw_spr     = spr_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// tb/tb_draw_arbiter.sv - directed bench for draw_arbiter
module tb_draw_arbiter;

    logic       clock;
    logic       resetn;
    logic [2:0] req;
    logic [8:0] x0, x1, x2;
    logic [7:0] y0, y1, y2;
    logic [1:0] spr0, spr1, spr2;
    logic       drw_done;
    logic       drw_start;
    logic [8:0] drw_x;
    logic [7:0] drw_y;
    logic [1:0] drw_spr;
    logic [2:0] grant;
    logic [2:0] done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    draw_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .resetn(resetn), .req(req),
        .x0(x0), .x1(x1), .x2(x2),
        .y0(y0), .y1(y1), .y2(y2),
        .spr0(spr0), .spr1(spr1), .spr2(spr2),
        .drw_done(drw_done), .drw_start(drw_start),
        .drw_x(drw_x), .drw_y(drw_y), .drw_spr(drw_spr),
        .grant(grant), .done(done), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk(tag, {11'd0, drw_start, grant, done, timeout_err, drw_x, drw_y, drw_spr}, 32'd0);
    endtask

    initial begin
        logic [2:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

        resetn = 1'b1; req = 3'b000; drw_done = 1'b0;
        x0 = 9'd95;  y0 = 8'd221; spr0 = 2'd1;
        x1 = 9'd126; y1 = 8'd17;  spr1 = 2'd2;
        x2 = 9'd300; y2 = 8'd5;   spr2 = 2'd3;
        #1 resetn = 1'b0;
        #1 all_zero("reset_outputs");
        tick(); tick();
        resetn = 1'b1;
        tick();

        // single request, job parameters latched, done one cycle after drw_done
        req = 3'b001;
        tick();
        chk("r031_start", drw_start, 1'b1);
        chk("r031_grant", grant, 3'b001);
        chk("r031_params", {drw_x, drw_y, drw_spr}, {9'd95, 8'd221, 2'd1});
        tick();
        chk("r031_start_pulse", drw_start, 1'b0);
        tick(); tick(); tick();
        chk("r031_no_done_yet", done, 3'b000);
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0; req = 3'b000;
        chk("r031_done", done, 3'b001);
        chk("r031_terr", timeout_err, 1'b0);
        chk("r031_grant_held", grant, 3'b001);
        tick();
        chk("r031_idle", {grant, done}, 6'd0);

        // fresh reset, all three requesting: 001,010,100,001
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r032_grant", grant, order[i]);
            chk("r032_start", drw_start, 1'b1);
            tick();
            drw_done = 1'b1;
            tick();
            drw_done = 1'b0;
            chk("r032_done", done, order[i]);
            tick();
            chk("r032_release", grant, 3'b000);
        end
        req = 3'b000;
        tick();

        // parameters frozen during job; dropping req does not abort
        req = 3'b010;
        tick();
        chk("r036_grant", grant, 3'b010);
        chk("r036_x_latch", drw_x, 9'd126);
        x1 = 9'd200; req = 3'b000;
        tick(); tick();
        chk("r036_x_busy", drw_x, 9'd126);
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        chk("r036_done", done, 3'b010);
        chk("r036_x_done", drw_x, 9'd126);
        tick();

        // timeout with limit 16
        req = 3'b010;
        tick();
        chk("r033_start", drw_start, 1'b1);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("r033_not_yet", done, 3'b000);
        req = 3'b000;
        tick();
        chk("r033_done", done, 3'b010);
        chk("r033_terr", timeout_err, 1'b1);
        tick();
        chk("r033_clear", {grant, done, timeout_err}, 7'd0);

        // drw_done coincident with the limit cycle is a normal completion
        req = 3'b010;
        tick(); tick();
        for (int i = 0; i < 15; i++) tick();
        req = 3'b000; drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        chk("r022_done", done, 3'b010);
        chk("r022_terr", timeout_err, 1'b0);
        tick();

        // drw_done during START is ignored
        req = 3'b001;
        tick();
        chk("r034_start", drw_start, 1'b1);
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0; req = 3'b000;
        chk("r034_ignored", done, 3'b000);
        chk("r034_grant", grant, 3'b001);
        tick(); tick();
        chk("r034_still_busy", done, 3'b000);
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        chk("r034_done", done, 3'b001);
        tick();

        // async reset mid-job, stray drw_done ignored, priority restarts at 0
        req = 3'b100;
        tick();
        chk("r035_grant", grant, 3'b100);
        tick();
        resetn = 1'b0;
        #1 all_zero("r035_async_reset");
        req = 3'b000;
        tick();
        resetn = 1'b1;
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        chk("r030_stray_done", {drw_start, done, grant}, 7'd0);
        req = 3'b101;
        tick();
        chk("r035_first", grant, 3'b001);
        tick();
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        chk("r035_done", done, 3'b001);
        tick(); tick();
        chk("r035_second", grant, 3'b100);
        req = 3'b000;
        tick();
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        chk("r035_done2", done, 3'b100);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
